// File: rtl/usr_pkg.sv
// Shared constants and state type for the universal shift register.
// The optional burst-rotate feature is selected by the USR_ROTATE_EN macro.
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } usr_state_t;

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst sequencer: latches the burst length and direction on start, then
// issues one shift-enable per cycle until the count runs out.
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_cnt,
  input  logic             dir,
  output logic             idle,
  output logic             busy,
  output logic             done,
  output logic             shift_en,
  output logic             shift_dir
);

  usr_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dir_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_RIGHT;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q   <= shift_cnt;
            dir_q   <= dir;
            state_q <= (shift_cnt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign idle      = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign shift_en  = (state_q == SHIFT);
  assign shift_dir = dir_q;

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit hold/shift/load register with an autonomous N-position burst shift.
// Define USR_ROTATE_EN to make burst shifts rotate instead of using sin_r/sin_l.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_cnt,
  input  logic             dir,
  output logic [WIDTH-1:0] qout,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  logic             idle;
  logic             shift_en;
  logic             shift_dir;
  logic             fill_r;
  logic             fill_l;
  logic [WIDTH-1:0] q_next;

  usr_burst_ctrl #(.CNT_W(CNT_W)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .shift_cnt (shift_cnt),
    .dir       (dir),
    .idle      (idle),
    .busy      (busy),
    .done      (done),
    .shift_en  (shift_en),
    .shift_dir (shift_dir)
  );

`ifdef USR_ROTATE_EN
  assign fill_r = qout[0];
  assign fill_l = qout[WIDTH-1];
`else
  assign fill_r = sin_r;
  assign fill_l = sin_l;
`endif

  // start in IDLE takes priority over manual modes and holds qout that edge
  always_comb begin
    q_next = qout;
    if (shift_en) begin
      if (shift_dir == DIR_LEFT) q_next = {qout[WIDTH-2:0], fill_l};
      else                       q_next = {fill_r, qout[WIDTH-1:1]};
    end else if (idle && !start && en) begin
      case (mode)
        MODE_HOLD: q_next = qout;
        MODE_SHR:  q_next = {sin_r, qout[WIDTH-1:1]};
        MODE_SHL:  q_next = {qout[WIDTH-2:0], sin_l};
        MODE_LOAD: q_next = din;
        default:   q_next = qout;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) qout <= '0;
    else      qout <= q_next;
  end

  assign sout_r = qout[0];
  assign sout_l = qout[WIDTH-1];

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
Parametrised successor to the 4-bit parallel-in/parallel-out register. Holds a WIDTH-bit word with five operations: hold, shift right, shift left, parallel load, and an autonomous burst shift of N positions. The burst shift has a busy/done handshake. The block serves as the general storage/serialiser element in the ALU datapath, for example for shift-by-N and serial transfer.

Parameters:
WIDTH, 4, register width in bits (>= 2)
CNT_W, 3, width of shift_cnt; must hold values 0..WIDTH (>= clog2(WIDTH+1))

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
en  input  1  enables manual mode operations while IDLE
mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
din  input  WIDTH  parallel load data
sin_r  input  1  serial in for right shift; enters the MSB
sin_l  input  1  serial in for left shift; enters the LSB
start  input  1  one-cycle pulse that requests a burst shift
shift_cnt  input  CNT_W  burst length, sampled with start
dir  input  1  burst direction: 0 right, 1 left; sampled with start
qout  output  WIDTH  register contents
sout_r  output  1  qout[0]; the bit leaving on a right shift
sout_l  output  1  qout[WIDTH-1]; the bit leaving on a left shift
busy  output  1  high while a burst is in progress
done  output  1  one-cycle pulse after the last burst shift

Behaviour:
- Reset: rst low immediately forces qout=0, busy=0, done=0, FSM=IDLE and the burst counter to 0. This applies mid-burst too; the burst is abandoned with no done pulse.
- sout_r and sout_l are combinational taps of qout.
- FSM states are IDLE, SHIFT, DONE.
- IDLE, start=0, en=1, at each edge:
  - mode 00: qout holds.
  - mode 01: qout <= {sin_r, qout[WIDTH-1:1]}.
  - mode 10: qout <= {qout[WIDTH-2:0], sin_l}.
  - mode 11: qout <= din.
- IDLE, start=0, en=0: qout holds.
- IDLE, start=1: start has priority over en/mode; qout holds that edge.
  - The edge latches shift_cnt into the counter and latches dir.
  - If shift_cnt=0: go to DONE; busy stays 0.
  - Else: go to SHIFT; busy=1 from this edge.
- SHIFT: every edge shifts qout one position in the latched dir and decrements the counter.
  - Serial source is sin_r or sin_l, sampled live.
  - en, mode and start are ignored.
  - When the counter reaches 0, go to DONE and drop busy.
- Latency: start edge k gives shifts at edges k+1..k+N, and done=1 during the cycle after edge k+N.
- DONE: done=1 for exactly one cycle, qout holds, then IDLE. start arriving in DONE is ignored.
- shift_cnt > WIDTH is legal. The burst simply shifts more than WIDTH positions.
- start while busy has no effect and the burst is not restarted.

Optional Feature:
USR_ROTATE_EN
- Defined: burst shifts rotate. A right shift feeds qout[0] into the MSB; a left shift feeds qout[WIDTH-1] into the LSB. sin_r/sin_l are ignored during a burst. Manual modes are unchanged.
- Undefined: bursts use sin_r/sin_l exactly as in manual modes.

Decomposition:
- Package usr_pkg:
  - Mode constants MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD.
  - Direction constants DIR_RIGHT, DIR_LEFT.
  - State typedef usr_state_t {IDLE, SHIFT, DONE}.
- Sub-module usr_burst_ctrl holds the FSM, counter and latched dir, and outputs busy, done and a shift-enable/direction to the datapath. The datapath stays in the top module.

Test Plan (WIDTH=4, CNT_W=3):
1. Load 1010, assert rst low between edges -> qout=0000, busy=0, done=0 immediately with no clock; after release, mode 00 keeps 0000.
2. en=1, mode=11, din=1010 -> qout=1010 next edge; mode=00 for 3 edges -> 1010 held; en=0 with mode=11, din=0101 -> still 1010.
3. From 0000, mode=01, sin_r=1 -> 1000, 1100, 1110, 1111. From 1111, mode=10, sin_l=0 -> 1110, 1100; sout_l/sout_r track qout.
4. qout=1011, start with shift_cnt=3, dir=0, sin_r=0, and mode=11 the same cycle -> load ignored; busy 3 cycles; qout 0101, 0010, 0001; done one cycle; second start mid-burst ignored.
5. start with shift_cnt=0 -> busy never 1, done=1 the cycle after start, qout unchanged. Reset during a cnt=4 burst after 2 shifts -> qout=0000, no done.
6. USR_ROTATE_EN defined: qout=1001, cnt=1, dir=1 -> 0011; cnt=4 -> returns to 1001. Undefined: the same cnt=1 case with sin_l=0 -> 0010.
